// File: rtl/tile_vga_renderer.sv
// tile_vga_renderer: VGA timing generator plus tile-mapped playfield renderer.
// Cells are fetched through a one-cycle synchronous read port and coloured
// through a packed 12-bit palette (bbbb_gggg_rrrr, entry 0 = background).
// Optional feature: define TILE_GRID_EN to draw the outer pixel ring of every
// non-empty tile in palette[0] (bevelled look); undefined draws solid tiles.
// CLK_DIV must be at least 2: the cell read needs two clk inside one pixel slot.
module tile_vga_renderer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned TILE_LOG2  = 4,
   parameter int unsigned COLS       = 10,
   parameter int unsigned ROWS       = 20,
   parameter int unsigned FIELD_X0   = 256,
   parameter int unsigned FIELD_Y0   = 80,
   parameter int unsigned COLOR_BITS = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [12*(2**COLOR_BITS)-1:0]     palette,
   output logic [$clog2(ROWS*COLS)-1:0]      cell_rd_addr,
   input  logic [COLOR_BITS-1:0]             cell_rd_data,
   output logic [3:0]                        r,
   output logic [3:0]                        g,
   output logic [3:0]                        b,
   output logic                              hs,
   output logic                              vs,
   output logic                              frame_start,
   output logic                              vblank
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned AW      = $clog2(ROWS * COLS);
   localparam int unsigned H_START = H_SYNC + H_BP;
   localparam int unsigned V_START = V_SYNC + V_BP;
   localparam int unsigned FIELD_W = COLS << TILE_LOG2;
   localparam int unsigned FIELD_H = ROWS << TILE_LOG2;

   logic [DW-1:0]         div;
   logic                  pe, pe_q1, pe_q2;
   logic [HW-1:0]         h_cnt;
   logic [VW-1:0]         v_cnt;

   // S1 combinational view of the current counter position
   int unsigned           hx, vy, xf, yf, col, row;
   logic                  h_act, v_act, in_field, hs_raw, vs_raw, at_origin;

   // pipeline registers
   logic                  in1, act1, hs1, vs1, vact1, org1;
   logic                  act2, hs2, vs2, vact2, org2;
   logic [COLOR_BITS-1:0] code2;
   logic [11:0]           pal_entry;

   assign pe = (div == DW'(CLK_DIV - 1));

   // Pixel-enable divider plus a two-clk trail of pe for the cell read return.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         div   <= '0;
         pe_q1 <= 1'b0;
         pe_q2 <= 1'b0;
      end else begin
         div   <= pe ? '0 : div + 1'b1;
         pe_q1 <= pe;
         pe_q2 <= pe_q1;
      end
   end

   // S0: horizontal and vertical counters, advancing only on pe.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pe) begin
         if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Raw timing, field membership and tile coordinates of the current pixel.
   always_comb begin
      // NOTE: every output of this block is assigned on every path, so no latch is inferred.
      hx        = 32'(h_cnt);
      vy        = 32'(v_cnt);
      hs_raw    = (hx >= H_SYNC);
      vs_raw    = (vy >= V_SYNC);
      h_act     = (hx >= H_START) && (hx < H_START + H_ACTIVE);
      v_act     = (vy >= V_START) && (vy < V_START + V_ACTIVE);
      // left/above the field wraps to a huge unsigned value and fails the range test
      xf        = hx - H_START - FIELD_X0;
      yf        = vy - V_START - FIELD_Y0;
      in_field  = h_act && v_act && (xf < FIELD_W) && (yf < FIELD_H);
      col       = xf >> TILE_LOG2;
      row       = yf >> TILE_LOG2;
      at_origin = (h_cnt == '0) && (v_cnt == '0);
   end

`ifdef TILE_GRID_EN
   localparam int unsigned TILE_MAX = (1 << TILE_LOG2) - 1;
   logic tile_edge, edge1;

   // Outer pixel ring of the tile under the current pixel.
   always_comb begin
      tile_edge = ((xf & TILE_MAX) == 0) || ((xf & TILE_MAX) == TILE_MAX) ||
                  ((yf & TILE_MAX) == 0) || ((yf & TILE_MAX) == TILE_MAX);
   end

   // Tile-edge flag travels with the S1 stage.
   always_ff @(posedge clk) begin
      if (rst)     edge1 <= 1'b0;
      else if (pe) edge1 <= tile_edge;
   end
`endif

   // S1: register fetch address and the timing flags; address holds outside the field.
   always_ff @(posedge clk) begin
      if (rst) begin
         cell_rd_addr <= '0;
         in1          <= 1'b0;
         act1         <= 1'b0;
         hs1          <= 1'b1;
         vs1          <= 1'b1;
         vact1        <= 1'b0;
         org1         <= 1'b0;
      end else if (pe) begin
         in1   <= in_field;
         act1  <= h_act && v_act;
         hs1   <= hs_raw;
         vs1   <= vs_raw;
         vact1 <= v_act;
         org1  <= at_origin;
         if (in_field) cell_rd_addr <= AW'(row * COLS + col);
      end
   end

   // S2: capture the returned cell code two clk after the address was registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         code2 <= '0;
      end else if (pe_q2) begin
`ifdef TILE_GRID_EN
         code2 <= (in1 && !edge1) ? cell_rd_data : '0;
`else
         code2 <= in1 ? cell_rd_data : '0;
`endif
      end
   end

   // Second delay stage for the timing flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         act2  <= 1'b0;
         hs2   <= 1'b1;
         vs2   <= 1'b1;
         vact2 <= 1'b0;
         org2  <= 1'b0;
      end else if (pe) begin
         act2  <= act1;
         hs2   <= hs1;
         vs2   <= vs1;
         vact2 <= vact1;
         org2  <= org1;
      end
   end

   // Palette entry selected by the captured cell code.
   always_comb begin
      pal_entry = palette[12*32'(code2) +: 12];
   end

   // S3: pin registers; colour is blanked outside the active area.
   always_ff @(posedge clk) begin
      if (rst) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         vblank      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pe && org2;
         if (pe) begin
            r      <= act2 ? pal_entry[3:0]  : 4'h0;
            g      <= act2 ? pal_entry[7:4]  : 4'h0;
            b      <= act2 ? pal_entry[11:8] : 4'h0;
            hs     <= hs2;
            vs     <= vs2;
            vblank <= !vact2;
         end
      end
   end

endmodule

// File: tb/tb_tile_vga_renderer.sv
// tb_tile_vga_renderer: scoreboard bench for tile_vga_renderer on a reduced
// geometry (field clipped on the right and bottom edges). Honours TILE_GRID_EN.
module tb_tile_vga_renderer;

   localparam int unsigned CLK_DIV    = 2;
   localparam int unsigned H_ACTIVE   = 40;
   localparam int unsigned H_FP       = 4;
   localparam int unsigned H_SYNC     = 6;
   localparam int unsigned H_BP       = 5;
   localparam int unsigned V_ACTIVE   = 30;
   localparam int unsigned V_FP       = 2;
   localparam int unsigned V_SYNC     = 2;
   localparam int unsigned V_BP       = 3;
   localparam int unsigned TILE_LOG2  = 3;
   localparam int unsigned COLS       = 4;
   localparam int unsigned ROWS       = 3;
   localparam int unsigned FIELD_X0   = 20;
   localparam int unsigned FIELD_Y0   = 10;
   localparam int unsigned COLOR_BITS = 2;

   localparam int unsigned HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned FRAME = HT * VT;
   localparam int unsigned TILE  = 1 << TILE_LOG2;
   localparam int unsigned AW    = $clog2(ROWS * COLS);
   localparam int unsigned NCOL  = 1 << COLOR_BITS;
   localparam int unsigned RUN   = 2 * FRAME * CLK_DIV + (20 * HT + 30) * CLK_DIV + 1;

   typedef struct packed {
      logic [3:0]    r;
      logic [3:0]    g;
      logic [3:0]    b;
      logic          hs;
      logic          vs;
      logic          vblank;
      logic          fs;
      logic [AW-1:0] addr;
   } pins_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [12*NCOL-1:0]    palette;
   logic [AW-1:0]         cell_rd_addr;
   logic [COLOR_BITS-1:0] cell_rd_data;
   logic [3:0]            r, g, b;
   logic                  hs, vs, frame_start, vblank;

   logic [COLOR_BITS-1:0] mem [ROWS*COLS];
   logic [11:0]           pal [NCOL];
   pins_t                 exp_q [$];

   int checks = 0;
   int errors = 0;

   tile_vga_renderer #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .TILE_LOG2(TILE_LOG2), .COLS(COLS), .ROWS(ROWS),
      .FIELD_X0(FIELD_X0), .FIELD_Y0(FIELD_Y0), .COLOR_BITS(COLOR_BITS)
   ) dut (
      .clk(clk), .rst(rst), .palette(palette),
      .cell_rd_addr(cell_rd_addr), .cell_rd_data(cell_rd_data),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
      .frame_start(frame_start), .vblank(vblank)
   );

   always #5 clk = ~clk;

   // cell RAM: data for an address is valid one clk after it is presented
   always @(posedge clk) cell_rd_data <= mem[cell_rd_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Cell index under screen position q (pixels since frame origin), -1 if none.
   function automatic int field_addr(input int unsigned q);
      int unsigned n, h, v, x, y;
      n = q % FRAME;
      h = n % HT;
      v = n / HT;
      if (h < H_SYNC + H_BP || h >= H_SYNC + H_BP + H_ACTIVE) return -1;
      if (v < V_SYNC + V_BP || v >= V_SYNC + V_BP + V_ACTIVE) return -1;
      x = h - (H_SYNC + H_BP);
      y = v - (V_SYNC + V_BP);
      if (x < FIELD_X0 || x >= FIELD_X0 + COLS * TILE) return -1;
      if (y < FIELD_Y0 || y >= FIELD_Y0 + ROWS * TILE) return -1;
      return int'(((y - FIELD_Y0) / TILE) * COLS + (x - FIELD_X0) / TILE);
   endfunction

   // Expected pins for screen position q.
   function automatic pins_t pixel_out(input int unsigned q);
      pins_t       e;
      int unsigned n, h, v, code;
      int          a;
      logic [11:0] c;
      n = q % FRAME;
      h = n % HT;
      v = n / HT;
      e = '0;
      e.hs     = (h >= H_SYNC);
      e.vs     = (v >= V_SYNC);
      e.vblank = !(v >= V_SYNC + V_BP && v < V_SYNC + V_BP + V_ACTIVE);
      if (!e.vblank && h >= H_SYNC + H_BP && h < H_SYNC + H_BP + H_ACTIVE) begin
         a    = field_addr(q);
         code = (a < 0) ? 0 : int'(mem[a]);
`ifdef TILE_GRID_EN
         if (a >= 0 && code != 0) begin
            int unsigned lx, ly;
            lx = (h - H_SYNC - H_BP - FIELD_X0) % TILE;
            ly = (v - V_SYNC - V_BP - FIELD_Y0) % TILE;
            if (lx == 0 || lx == TILE - 1 || ly == 0 || ly == TILE - 1) code = 0;
         end
`endif
         c   = pal[code];
         e.r = c[3:0];
         e.g = c[7:4];
         e.b = c[11:8];
      end
      return e;
   endfunction

   // Reference model: predicts the pins visible after every clk edge.
   always @(posedge clk) begin : model
      pins_t       e;
      int unsigned p;
      int          a;
      int unsigned j_static;
      static int unsigned j = 0;
      static logic [AW-1:0] exp_addr = '0;
      if (rst) begin
         j        = 0;
         exp_addr = '0;
         e        = '0;
         e.hs     = 1'b1;
         e.vs     = 1'b1;
         e.vblank = 1'b1;
      end else begin
         j++;
         j_static = j;
         p = j_static / CLK_DIV;
         if (j_static % CLK_DIV == 0) begin
            a = field_addr(p - 1);
            if (a >= 0) exp_addr = AW'(a);
         end
         if (p < 3) begin
            e        = '0;
            e.hs     = 1'b1;
            e.vs     = 1'b1;
            e.vblank = 1'b1;
         end else begin
            e    = pixel_out(p - 3);
            e.fs = (j_static % CLK_DIV == 0) && ((p - 3) % FRAME == 0);
         end
      end
      e.addr = exp_addr;
      exp_q.push_back(e);
   end

   // Monitor: compares pins against the scoreboard and checks sync widths/periods.
   int      cyc = 0;
   int      fs_last = 0;
   bit      fs_valid = 0;
   int      fs_count = 0;
   int      hs_run = 0;
   bit      hs_ok = 0;

   always @(negedge clk) begin : monitor
      pins_t e, a;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {r, g, b, hs, vs, vblank, frame_start, cell_rd_addr};
         check("pins", 64'(a), 64'(e));
      end
      if (rst) begin
         fs_valid = 0;
         hs_ok    = 0;
         hs_run   = 0;
      end else begin
         if (frame_start) begin
            if (fs_valid) check("frame_period", 64'(cyc - fs_last), 64'(FRAME * CLK_DIV));
            fs_last  = cyc;
            fs_valid = 1;
            fs_count++;
         end
         if (!hs) begin
            hs_run++;
         end else begin
            if (hs_ok && hs_run != 0) check("hs_width", 64'(hs_run), 64'(H_SYNC * CLK_DIV));
            hs_run = 0;
            hs_ok  = 1;
         end
      end
   end

   initial begin
      for (int seg = 0; seg < 3; seg++) begin
         @(negedge clk);
         rst = 1'b1;
         foreach (mem[i]) mem[i] = COLOR_BITS'($urandom_range(0, NCOL - 1));
         foreach (pal[i]) pal[i] = 12'($urandom);
         if (seg == 1) pal[0] = 12'hFFF;
         for (int k = 0; k < int'(NCOL); k++) palette[12*k +: 12] = pal[k];
         repeat (3) @(negedge clk);
         rst = 1'b0;
         // every run ends mid-frame, so the next reset aborts a frame in progress
         repeat (RUN) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("frame_starts_seen", 64'(fs_count >= 6), 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
